matmul_seq_ctrl: RTL
====================

# matmul_seq_ctrl

Sequencing controller for the M×N×L matrix-multiply datapath (result Gg = G·g). It time-multiplexes a single W×W multiplier and accumulator across all M·L·N product terms instead of instantiating M·L·N multipliers. It sits between the operand producer and the transform stage that consumes Gg, with valid/ready handshakes on both sides. It accepts one operand pair, runs a fixed 36-cycle schedule (default sizes), and then holds the result until the consumer takes it.

## Interface
- W, 8, element width in bits (unsigned)
- M, 4, rows of G and of result
- N, 3, columns of G / rows of g (inner dimension)
- L, 3, columns of g and of result
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  controller can accept operands
- transformation_mtx  in  M*N*W  G; element (m,n) at [m*N*W + n*W +: W]
- input_mtx  in  N*L*W  g; element (n,l) at [n*L*W + l*W +: W]
- out_valid  out  1  result_mtx complete and stable
- out_ready  in  1  consumer takes result
- result_mtx  out  M*L*W  Gg; element (m,l) at [m*L*W + l*W +: W]
- busy  out  1  state is CALC or DONE

## Operation
- There is one clock domain. rstn is asynchronous: on assertion, all registers clear immediately; release is sampled on clk.
- The FSM has three states: IDLE, CALC and DONE. The reset state is IDLE.
- **IDLE**
  - in_ready=1 and out_valid=0.
  - On in_valid&in_ready:
    - capture both matrices into internal operand registers;
    - clear result_mtx and the accumulator;
    - set counters m=l=n=0;
    - go to CALC.
- **CALC** performs one MAC per cycle: prod = G[m][n]*g[n][l] (2W bits), and sum = acc + prod.
  - If n<N-1: acc <= sum and n <= n+1.
  - If n==N-1:
    - result_mtx element (m,l) <= sum[W-1:0];
    - acc <= 0 and n <= 0;
    - l <= l+1. If l==L-1, then l <= 0 and m <= m+1.
  - If m==M-1, l==L-1 and n==N-1: write the last element and go to DONE.
- The iteration order is n innermost, then l, then m. Results are therefore written row-major, element (0,0) first.
- The accumulator width is 2W+clog2(N) bits, so there is no internal overflow. The stored element is the sum modulo 2^W.
- **DONE**
  - out_valid=1; result_mtx, the operand registers and the counters are held.
  - On out_ready: go to IDLE.
- in_ready=0 in CALC and DONE. in_valid is ignored there, and the operand inputs may change freely without affecting the result.
- result_mtx contents are meaningful only while out_valid=1. During CALC, elements not yet computed read 0.
- busy = (state != IDLE).
- in_ready, out_valid and busy are decoded from registered state only; there are no combinational paths from inputs.

## Timing
- Reset values:
  - in_ready=1 and busy=0 (state IDLE);
  - out_valid=0;
  - result_mtx=0;
  - accumulator, counters and operand registers are 0.
- Accept edge E0 (in_valid&in_ready sampled high). MAC edges are E1..E(M·L·N); the default is 36.
- out_valid rises after edge E36, which is 36 cycles after the accept edge.
- Result element (m,l) is written at edge E((m·L+l)·N+N).
- Handshake completes at the first edge where out_valid&out_ready are both high. in_ready rises after that edge. The earliest next accept is the following edge, which gives a throughput of one operation per M·L·N+2 cycles.
- If out_ready is already high when DONE is entered, DONE lasts exactly one cycle.
- Reset mid-CALC or mid-DONE: the FSM returns to IDLE immediately and all outputs return to reset values. A partial result is never presented.
- in_valid during CALC or DONE: no effect, and no queuing.

## Test plan
- **All-equal operands:** G all 0x01, g all 0x02 -> out_valid exactly 36 cycles after accept; every result element is 0x06.
- **Wrap-around:** G all 0xFF, g all 0xFF -> every element is 0x03 (3·0xFE01 = 0x2FA03, low byte).
- **Ordering/indexing:** G(m,n)=1 if m==n else 0; g(n,l)=n·3+l+1 -> result rows 0..2 = 1..9 row-major, row 3 = 0. Also check write edges E3, E6, … E36 for elements (0,0), (0,1), …, (3,2).
- **Back-pressure and busy-input:**
  - Hold out_ready=0 for 10 cycles after out_valid -> out_valid and result stay stable, in_ready stays 0.
  - Toggle in_valid and new operands during CALC -> the result is unchanged.
- **Back-to-back:** in_valid held high with two operand sets, out_ready=1 -> results 1 and 2 are both correct; the accepts are 38 edges apart.
- **Reset mid-operation:** assert rstn=0 at E20 -> in_ready=1, out_valid=0 and result_mtx=0 immediately. After release, a fresh operation with G=g all 0x01 returns all 0x03.

Source files
------------

// File: rtl/matmul_seq_ctrl.sv
// Sequencing controller for Gg = G*g: one shared WxW multiplier and accumulator
// stepped through all M*L*N product terms, with valid/ready on both sides.
module matmul_seq_ctrl #(
  parameter int unsigned W = 8,
  parameter int unsigned M = 4,
  parameter int unsigned N = 3,
  parameter int unsigned L = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M*N*W-1:0] transformation_mtx,
  input  logic [N*L*W-1:0] input_mtx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M*L*W-1:0] result_mtx,
  output logic             busy
);

  localparam int unsigned MW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned LW = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned AW = 2 * W + $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [M*N*W-1:0]   r_g;
  logic [N*L*W-1:0]   r_x;
  logic [M*L*W-1:0]   r_res;
  logic [AW-1:0]      r_acc;
  logic [MW-1:0]      r_m;
  logic [LW-1:0]      r_l;
  logic [NW-1:0]      r_n;

  logic [W-1:0]       w_a;
  logic [W-1:0]       w_b;
  logic [PW-1:0]      w_prod;
  logic [AW-1:0]      w_sum;
  logic               w_n_last;
  logic               w_l_last;
  logic               w_m_last;

  assign w_a      = r_g[(32'(r_m) * N + 32'(r_n)) * W +: W];
  assign w_b      = r_x[(32'(r_n) * L + 32'(r_l)) * W +: W];
  assign w_prod   = PW'(w_a) * PW'(w_b);
  assign w_sum    = r_acc + AW'(w_prod);
  assign w_n_last = (r_n == NW'(N - 1));
  assign w_l_last = (r_l == LW'(L - 1));
  assign w_m_last = (r_m == MW'(M - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_CALC;
      S_CALC:  if (w_n_last && w_l_last && w_m_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_g   <= '0;
      r_x   <= '0;
      r_res <= '0;
      r_acc <= '0;
      r_m   <= '0;
      r_l   <= '0;
      r_n   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_g   <= transformation_mtx;
            r_x   <= input_mtx;
            r_res <= '0;
            r_acc <= '0;
            r_m   <= '0;
            r_l   <= '0;
            r_n   <= '0;
          end
        end
        S_CALC: begin
          if (!w_n_last) begin
            r_acc <= w_sum;
            r_n   <= r_n + 1'b1;
          end else begin
            // Element is complete on the last inner term; store its low W bits.
            r_res[(32'(r_m) * L + 32'(r_l)) * W +: W] <= w_sum[W-1:0];
            r_acc <= '0;
            r_n   <= '0;
            if (w_l_last) begin
              r_l <= '0;
              r_m <= r_m + 1'b1;
            end else begin
              r_l <= r_l + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign result_mtx = r_res;

endmodule
